// File: rtl/i2s_tx.sv
// I2S (Philips) transmitter: sample FIFO plus serializer that sends each mono sample on
// both channels, with BCLK/LRCLK generated from the system clock.
module i2s_tx #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            enable_i,
  input  logic [DATA_W-1:0]               sample_i,
  input  logic                            valid_i,
  output logic                            ready_o,
  output logic                            bclk_o,
  output logic                            lrclk_o,
  output logic                            sdata_o,
  output logic                            underrun_o,
  input  logic                            clr_underrun_i,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count_o
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned AddrW = PtrW - 1;
  localparam int unsigned SlotW = $clog2(2 * DATA_W);
  localparam int unsigned IdxW  = $clog2(DATA_W);
  localparam int unsigned DivW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [SlotW-1:0] LastSlot  = SlotW'(2 * DATA_W - 1);
  localparam logic [SlotW-1:0] RightSlot = SlotW'(DATA_W);
  localparam logic [DivW-1:0]  DivLast   = DivW'(CLK_DIV - 1);
  localparam logic [IdxW-1:0]  MsbIdx    = IdxW'(DATA_W - 1);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [DivW-1:0]   div_q, div_d;
  logic [SlotW-1:0]  slot_q, slot_d, slot_nxt, slot_after;
  logic [IdxW-1:0]   slot_pos, bit_idx;
  logic [DATA_W-1:0] hold_q, hold_d, head;
  logic              bclk_q, bclk_d, lrclk_q, lrclk_d, sdata_q, sdata_d;
  logic              underrun_q, underrun_d;
  logic              full, empty, push, pop, tick, shift_ev, frame_start;

  always_comb begin
    empty       = (wptr_q == rptr_q);
    full        = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                  (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);
    push        = valid_i && !full;
    head        = mem_q[rptr_q[AddrW-1:0]];
    tick        = enable_i && (div_q == DivLast);
    shift_ev    = tick && bclk_q;
    slot_nxt    = (slot_q == LastSlot) ? '0 : slot_q + SlotW'(1);
    slot_after  = (slot_nxt == LastSlot) ? '0 : slot_nxt + SlotW'(1);
    slot_pos    = (slot_nxt >= RightSlot) ? IdxW'(slot_nxt - RightSlot) : IdxW'(slot_nxt);
    bit_idx     = MsbIdx - slot_pos;
    frame_start = shift_ev && (slot_nxt == '0);
    // Pop sees only the registered pointers, so a same-cycle push is never bypassed.
    pop         = frame_start && !empty;
  end

  always_comb begin
    wptr_d     = wptr_q + PtrW'(push);
    rptr_d     = rptr_q + PtrW'(pop);
    div_d      = div_q;
    bclk_d     = bclk_q;
    lrclk_d    = lrclk_q;
    sdata_d    = sdata_q;
    slot_d     = slot_q;
    hold_d     = hold_q;
    underrun_d = underrun_q;

    if (frame_start && empty) begin
      underrun_d = 1'b1;
    end else if (clr_underrun_i) begin
      underrun_d = 1'b0;
    end

    if (!enable_i) begin
      div_d   = '0;
      bclk_d  = 1'b0;
      lrclk_d = 1'b0;
      sdata_d = 1'b0;
      slot_d  = LastSlot;
    end else begin
      div_d = tick ? '0 : div_q + DivW'(1);
      if (tick) begin
        bclk_d = !bclk_q;
      end
      if (shift_ev) begin
        slot_d  = slot_nxt;
        // LRCLK announces the channel of the following slot.
        lrclk_d = (slot_after >= RightSlot);
        if (frame_start) begin
          hold_d  = empty ? '0 : head;
          sdata_d = empty ? 1'b0 : head[DATA_W-1];
        end else begin
          sdata_d = hold_q[bit_idx];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      div_q      <= '0;
      bclk_q     <= 1'b0;
      lrclk_q    <= 1'b0;
      sdata_q    <= 1'b0;
      slot_q     <= LastSlot;
      hold_q     <= '0;
      underrun_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      div_q      <= div_d;
      bclk_q     <= bclk_d;
      lrclk_q    <= lrclk_d;
      sdata_q    <= sdata_d;
      slot_q     <= slot_d;
      hold_q     <= hold_d;
      underrun_q <= underrun_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wptr_q[AddrW-1:0]] <= sample_i;
    end
  end

  assign ready_o      = !full;
  assign bclk_o       = bclk_q;
  assign lrclk_o      = lrclk_q;
  assign sdata_o      = sdata_q;
  assign underrun_o   = underrun_q;
  assign fifo_count_o = wptr_q - rptr_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Randomized bench for i2s_tx against a time-based frame model: expected serial outputs are
// derived from the number of enabled clocks since the serializer last started.
module tb_i2s_tx;

  localparam int unsigned DW = 16;
  localparam int unsigned CD = 2;
  localparam int unsigned FD = 4;
  localparam int unsigned CW = $clog2(FD) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [DW-1:0] sample = '0;
  logic          valid = 1'b0;
  logic          clr = 1'b0;
  logic          ready, bclk, lrclk, sdata, underrun;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  i2s_tx #(.DATA_W(DW), .CLK_DIV(CD), .FIFO_DEPTH(FD)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .enable_i      (enable),
    .sample_i      (sample),
    .valid_i       (valid),
    .ready_o       (ready),
    .bclk_o        (bclk),
    .lrclk_o       (lrclk),
    .sdata_o       (sdata),
    .underrun_o    (underrun),
    .clr_underrun_i(clr),
    .fifo_count_o  (count)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model state: enabled clocks since start, queued samples, sample on the wire, sticky flag.
  int            t = 0;
  logic [DW-1:0] q[$];
  logic [DW-1:0] hold = '0;
  logic          uflag = 1'b0;
  logic          pushed = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_frame_start(input int tt);
    return (tt > 0) && (tt % (2 * CD) == 0) && (((tt / (2 * CD)) - 1) % (2 * DW) == 0);
  endfunction

  task automatic model_edge();
    int  sz;
    bit  fs;
    pushed = 1'b0;
    if (!rst_n) begin
      t = 0;
      q.delete();
      hold  = '0;
      uflag = 1'b0;
    end else begin
      sz = q.size();
      fs = 1'b0;
      if (enable) begin
        t++;
        fs = is_frame_start(t);
      end else begin
        t = 0;
      end
      if (clr) uflag = 1'b0;
      if (fs) begin
        if (sz > 0) hold = q.pop_front();
        else begin
          hold  = '0;
          uflag = 1'b1;
        end
      end
      if (valid && (sz < int'(FD))) begin
        q.push_back(sample);
        pushed = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    int   k, b;
    logic eb, el, es;
    k  = t / (2 * CD);
    eb = ((t / CD) % 2) == 1;
    if (k == 0) begin
      el = 1'b0;
      es = 1'b0;
    end else begin
      b  = (k - 1) % (2 * DW);
      el = ((b + 1) % (2 * DW)) >= DW;
      es = hold[DW-1-(b%DW)];
    end
    check("bclk", 32'(bclk), 32'(eb));
    check("lrclk", 32'(lrclk), 32'(el));
    check("sdata", 32'(sdata), 32'(es));
    check("underrun", 32'(underrun), 32'(uflag));
    check("fifo_count", 32'(count), 32'(q.size()));
    check("ready", 32'(ready), 32'(q.size() < int'(FD)));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push_one(input logic [DW-1:0] v);
    sample = v;
    valid  = 1'b1;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (pushed) break;
    end
    valid = 1'b0;
  endtask

  initial begin
    // Reset and a single sample 16'h8001
    run(3);
    rst_n  = 1'b1;
    enable = 1'b1;
    push_one(16'h8001);
    run(300);

    // Fill with serializer disabled, fifth sample waits upstream
    enable = 1'b0;
    tick();
    for (int i = 1; i <= 4; i++) push_one(DW'(16'h1111 * i));
    sample = 16'h5555;
    valid  = 1'b1;
    run(6);
    enable = 1'b1;
    for (int i = 0; i < 800; i++) begin
      tick();
      if (pushed) valid = 1'b0;
    end
    valid = 1'b0;

    // Underrun clear mid-frame, then set again by the next empty frame
    run(40);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    run(200);

    // Push landing exactly on a frame-start edge with the FIFO empty
    for (int i = 0; i < 200; i++) begin
      if (is_frame_start(t + 1)) break;
      tick();
    end
    sample = 16'hA5C3;
    valid  = 1'b1;
    tick();
    valid = 1'b0;
    run(300);

    // One-cycle reset mid-frame with three samples queued
    enable = 1'b0;
    tick();
    push_one(16'h1234);
    push_one(16'h4321);
    push_one(16'h0F0F);
    enable = 1'b1;
    run(60);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    run(200);

    // Disable at slot 7, hold 10 clocks, restart with the next sample
    push_one(16'hC0DE);
    push_one(16'h7E57);
    for (int i = 0; i < 400; i++) begin
      if (t >= 4 && (t % (2 * CD) == 0) && (((t / (2 * CD)) - 1) % (2 * DW) == 7)) break;
      tick();
    end
    enable = 1'b0;
    run(10);
    enable = 1'b1;
    run(400);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      valid  = ($urandom_range(0, 99) < 3);
      sample = DW'($urandom());
      clr    = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 999) < 3) enable = ~enable;
      if ($urandom_range(0, 1999) < 1) rst_n = 1'b0;
      else rst_n = 1'b1;
      tick();
    end
    valid = 1'b0;
    clr   = 1'b0;
    rst_n = 1'b1;
    run(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- Downstream output stage of the synthesizer voice path.
- Accepts signed PCM samples from the oscillator/gain stage over a valid/ready handshake and buffers them in a small FIFO.
- Serializes each sample as a standard Philips I2S stereo frame (mono duplicated to left and right) to drive an external DAC.
- Generates BCLK and LRCLK internally from the system clock.

Parameters:
- DATA_W, 16: sample width in bits; samples are signed two's complement.
- CLK_DIV, 4: system clocks per BCLK half-period; must be ≥1.
- FIFO_DEPTH, 4: sample FIFO entries; must be a power of 2, ≥2.

Ports:
- clk_i  in  1  system clock; all logic on its rising edge.
- rst_ni  in  1  synchronous active-low reset.
- enable_i  in  1  1 = serializer runs; 0 = serial outputs idle.
- sample_i  in  DATA_W  PCM sample from the upstream synth stage.
- valid_i  in  1  sample_i is valid.
- ready_o  out  1  FIFO can accept; equals !full.
- bclk_o  out  1  I2S bit clock.
- lrclk_o  out  1  I2S word select; 0 = left, 1 = right.
- sdata_o  out  1  I2S serial data, MSB first.
- underrun_o  out  1  sticky; a frame started with the FIFO empty.
- clr_underrun_i  in  1  synchronous clear for underrun_o.
- fifo_count_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst_ni=0 at a clk_i edge):
  - bclk_o=0, lrclk_o=0, sdata_o=0, underrun_o=0.
  - FIFO empty, fifo_count_o=0, ready_o=1.
  - div_q=0, bit_cnt=2*DATA_W-1.
  - Reset mid-frame aborts the frame immediately and discards all FIFO contents.
- Push:
  - An entry is written when valid_i && ready_o at a clock edge.
  - No combinational path from valid_i to ready_o.
- Divider:
  - When enable_i=1, div_q counts 0..CLK_DIV-1. At terminal count, div_q returns to 0 and bclk_o toggles.
  - Each 1→0 toggle of bclk_o is a shift event.
  - BCLK period = 2*CLK_DIV clocks. Frame = 2*DATA_W BCLK periods.
- Shift event:
  - bit_cnt advances mod 2*DATA_W to a new value b.
  - Slot b belongs to channel b/DATA_W and carries sample bit DATA_W-1-(b mod DATA_W).
  - sdata_o is updated to the slot-b bit in the same edge that bclk_o falls.
  - lrclk_o is updated to the channel of slot (b+1) mod 2*DATA_W. LRCLK therefore leads the MSB by one BCLK, per the I2S standard.
- Frame start (shift event with new b=0):
  - If the FIFO is non-empty: pop the head into hold_q and set sdata_o=head[DATA_W-1].
  - If the FIFO is empty: hold_q=0, sdata_o=0, underrun_o←1.
  - No bypass: a push in the same cycle as frame start is not visible to that pop.
  - The right channel (b=DATA_W..2*DATA_W-1) re-sends hold_q.
- Simultaneous push and pop in one cycle: fifo_count_o is unchanged; both operations occur.
- FIFO wrap:
  - Read and write pointers are $clog2(FIFO_DEPTH)+1 bits wide.
  - Full when the pointer MSBs differ and the lower bits are equal.
- underrun_o:
  - Set dominates clear when both occur in the same cycle.
  - Otherwise clr_underrun_i=1 clears it on the next edge.
- enable_i=0:
  - Synchronously forces div_q, bit_cnt, bclk_o, lrclk_o and sdata_o to their reset values.
  - FIFO contents and underrun_o are retained; pushes are still accepted.
  - Re-enabling starts a clean frame. The first shift event (slot 0) occurs 2*CLK_DIV clocks after enable_i rises.
- Sample rate = f_clk / (2*CLK_DIV*2*DATA_W). Upstream must provide samples at or above this rate to avoid underrun.

Test Plan:
- Reset, enable, push 16'h8001 at CLK_DIV=2 and DATA_W=16 -> first bclk_o fall 4 clocks after enable. Left slots carry 1,0,…,0,1 and right slots repeat them. lrclk_o rises at the fall preceding right MSB (b=15) and falls at b=31. underrun_o=0.
- Push 5 samples back-to-back with FIFO_DEPTH=4 and the serializer disabled -> ready_o=0 after the 4th accept, fifo_count_o=4, 5th sample held by upstream. Enable -> frames emit samples 1–4 in order.
- Enable with FIFO empty -> first frame all zeros, underrun_o=1. Pulse clr_underrun_i mid-frame -> underrun_o=0. Next frame empty again -> underrun_o=1.
- Push timed to land exactly on a frame-start cycle with FIFO empty -> that frame outputs 0 with underrun_o=1. Next frame outputs the pushed sample.
- Assert rst_ni=0 for one clock mid-frame with 3 samples queued -> all outputs return to reset values and fifo_count_o=0. Next frame outputs zeros.
- Drop enable_i mid-frame at b=7, hold 10 clocks, re-raise -> bclk_o, lrclk_o and sdata_o stay 0 while disabled. Restart begins at slot 0 with the next FIFO sample; the partially sent sample is not resent.
